// File: rtl/instr_sequencer_if.sv
// Sequencer-side bus: synchronous program-memory read port plus the
// processor issue/complete handshake.
interface instr_sequencer_if #(
    parameter int PC_W = 5
);
    logic            mem_rd;
    logic [PC_W-1:0] mem_addr;
    logic [8:0]      mem_data;
    logic [8:0]      proc_din;
    logic            proc_run;
    logic            proc_done;

    modport master (
        output mem_rd, mem_addr, proc_din, proc_run,
        input  mem_data, proc_done
    );

    modport slave (
        input  mem_rd, mem_addr, proc_din, proc_run,
        output mem_data, proc_done
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 9-bit words from a synchronous memory, issues
// them to a processor (mvi carries a second immediate word) and waits for done.
module instr_sequencer #(
    parameter int PC_W = 5,
    parameter int TMO  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    instr_sequencer_if.master bus,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              halted,
    output logic              err
);
    localparam int              CNT_W    = (TMO < 2) ? 1 : $clog2(TMO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 1);
    localparam logic [2:0]      OP_MVI   = 3'b001;
    localparam logic [2:0]      OP_HALT  = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE, S_F1, S_L1, S_F2, S_L2, S_ISSUE, S_IMM, S_EXEC, S_HALT
    } state_t;

    state_t           r_state, w_next;
    logic [PC_W-1:0]  r_pc;
    logic [8:0]       r_ir, r_imm;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stop, r_err;
    logic             w_mvi, w_wait, w_done, w_tmo, w_stop_eff;
    logic [PC_W-1:0]  w_pc_inc;

    assign w_mvi      = (r_ir[8:6] == OP_MVI);
    assign w_wait     = (r_state == S_IMM) || (r_state == S_EXEC);
    assign w_done     = w_wait && bus.proc_done;
    assign w_tmo      = w_wait && !bus.proc_done && (r_cnt == CNT_LAST);
    // a stop arriving in the completion cycle itself still counts
    assign w_stop_eff = r_stop || stop;
    assign w_pc_inc   = r_pc + PC_W'(1);

    assign pc  = r_pc;
    assign err = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_F1;
            S_F1:    w_next = S_L1;
            S_L1: begin
                if (bus.mem_data[8:6] == OP_HALT)     w_next = S_HALT;
                else if (bus.mem_data[8:6] == OP_MVI) w_next = S_F2;
                else                                  w_next = S_ISSUE;
            end
            S_F2:    w_next = S_L2;
            S_L2:    w_next = S_ISSUE;
            S_ISSUE: w_next = w_mvi ? S_IMM : S_EXEC;
            S_IMM, S_EXEC: begin
                if (w_done)     w_next = w_stop_eff ? S_HALT : S_F1;
                else if (w_tmo) w_next = S_HALT;
                else            w_next = S_EXEC;
            end
            S_HALT:  if (start) w_next = S_F1;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_rd   = 1'b0;
        bus.mem_addr = r_pc;
        bus.proc_din = 9'd0;
        bus.proc_run = 1'b0;
        busy         = 1'b0;
        halted       = 1'b0;
        case (r_state)
            S_F1:    begin bus.mem_rd = 1'b1; busy = 1'b1; end
            S_L1:    busy = 1'b1;
            S_F2:    begin bus.mem_rd = 1'b1; bus.mem_addr = w_pc_inc; busy = 1'b1; end
            S_L2:    busy = 1'b1;
            S_ISSUE: begin bus.proc_din = r_ir; bus.proc_run = 1'b1; busy = 1'b1; end
            S_IMM:   begin bus.proc_din = r_imm; busy = 1'b1; end
            S_EXEC:  begin bus.proc_din = w_mvi ? r_imm : r_ir; busy = 1'b1; end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc   <= '0;
            r_ir   <= '0;
            r_imm  <= '0;
            r_cnt  <= '0;
            r_stop <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_L1) r_ir  <= bus.mem_data;
            if (r_state == S_L2) r_imm <= bus.mem_data;

            if (r_state == S_ISSUE)          r_cnt <= '0;
            else if (w_wait && !w_done && !w_tmo) r_cnt <= r_cnt + CNT_W'(1);

            if (w_done) r_pc <= r_pc + (w_mvi ? PC_W'(2) : PC_W'(1));

            // HALT is not busy, so start always wins over a same-cycle stop there
            if (busy && stop)                     r_stop <= 1'b1;
            else if ((r_state == S_HALT) && start) r_stop <= 1'b0;

            if (w_tmo)                            r_err <= 1'b1;
            else if ((r_state == S_HALT) && start) r_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: memory and processor models plus an issue log,
// directed scenarios and random programs checked against a program walker.
module tb_instr_sequencer;
    localparam int PC_W = 5;
    localparam int TMO  = 7;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic [PC_W-1:0] pc;
    logic            busy, halted, err;

    instr_sequencer_if #(.PC_W(PC_W)) bus ();

    instr_sequencer #(.PC_W(PC_W), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .bus(bus), .pc(pc), .busy(busy), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int n_checks = 0;

    // synchronous program memory
    logic [8:0] mem [0:31];
    always @(posedge clk) if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

    // processor: done pulses lat cycles after run; lat=0 means never
    int lat = 1;
    int r_wait = 0;
    always @(posedge clk or negedge reset) begin
        if (!reset)            r_wait <= 0;
        else if (bus.proc_run) r_wait <= lat;
        else if (r_wait > 0)   r_wait <= r_wait - 1;
    end
    assign bus.proc_done = (r_wait == 1);

    // issue log: word at run, word in the following cycle, cycles since fetch
    int         cyc = 0, rd_cnt = 0, log_n = 0, last_fetch = 0, inv_viol = 0;
    logic       pend = 1'b0;
    logic [8:0] log_inst [1024];
    logic [8:0] log_next [1024];
    int         log_lat  [1024];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (pend && log_n > 0) log_next[log_n-1] <= bus.proc_din;
        pend <= bus.proc_run && (log_n < 1024);
        if (bus.mem_rd) rd_cnt <= rd_cnt + 1;
        if (bus.mem_rd && bus.mem_addr == pc) last_fetch <= cyc;
        if (bus.proc_run && log_n < 1024) begin
            log_inst[log_n] <= bus.proc_din;
            log_lat[log_n]  <= cyc - last_fetch;
            log_n           <= log_n + 1;
        end
        if ((bus.proc_run && bus.mem_rd) || (bus.proc_run && !busy)) begin
            inv_viol <= inv_viol + 1;
            $display("invariant violated at cycle %0d: run=%b rd=%b busy=%b",
                     cyc, bus.proc_run, bus.mem_rd, busy);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic load_halts();
        for (int a = 0; a < 32; a++) mem[a] = 9'o700;
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_halt(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk); #1;
            if (halted) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_run(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk); #1;
            if (bus.proc_run) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        int rd0, run0;
        reset = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (pc !== '0) begin errors++; $display("FAIL reset_pc: got %0d want 0", pc); end
        n_checks++; if ({busy, halted, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, halted, err}); end
        n_checks++; if ({bus.mem_rd, bus.proc_run} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {bus.mem_rd, bus.proc_run}); end
        n_checks++; if (bus.proc_din !== 9'd0) begin errors++; $display("FAIL reset_din: got %0o want 0", bus.proc_din); end
        reset = 1'b1;
        rd0 = rd_cnt; run0 = log_n;
        repeat (6) begin @(negedge clk); #1; end
        n_checks++; if (rd_cnt !== rd0) begin errors++; $display("FAIL idle_no_read: got %0d reads want 0", rd_cnt - rd0); end
        n_checks++; if (log_n !== run0 || busy !== 1'b0) begin errors++; $display("FAIL idle_no_run: got runs=%0d busy=%b want 0/0", log_n - run0, busy); end
    endtask

    task automatic test_mv();
        int base; bit ok;
        load_halts(); mem[0] = 9'o010; lat = 1;
        do_reset(); base = log_n;
        pulse_start(); wait_halt(100, ok);
        n_checks++; if (!ok) begin errors++; $display("FAIL mv_halt_wait: got timeout want halted"); end
        n_checks++; if (log_n - base !== 1) begin errors++; $display("FAIL mv_runs: got %0d want 1", log_n - base); end
        n_checks++; if (log_inst[base] !== 9'o010) begin errors++; $display("FAIL mv_din: got %0o want 010", log_inst[base]); end
        n_checks++; if (log_lat[base] !== 2) begin errors++; $display("FAIL mv_latency: got %0d want 2", log_lat[base]); end
        n_checks++; if (pc !== 5'd1) begin errors++; $display("FAIL mv_pc: got %0d want 1", pc); end
    endtask

    task automatic test_mvi();
        int base; bit ok;
        load_halts();
        mem[0] = 9'o010; mem[1] = 9'o020; mem[2] = 9'o030; mem[3] = 9'o120; mem[4] = 9'd77;
        lat = 1; do_reset(); base = log_n;
        pulse_start(); wait_halt(100, ok);
        n_checks++; if (!ok || log_n - base !== 4) begin errors++; $display("FAIL mvi_runs: got %0d ok=%b want 4", log_n - base, ok); end
        n_checks++; if (log_inst[base+3] !== 9'o120) begin errors++; $display("FAIL mvi_inst: got %0o want 120", log_inst[base+3]); end
        n_checks++; if (log_next[base+3] !== 9'd77) begin errors++; $display("FAIL mvi_imm: got %0d want 77", log_next[base+3]); end
        n_checks++; if (log_lat[base+3] !== 4) begin errors++; $display("FAIL mvi_latency: got %0d want 4", log_lat[base+3]); end
        n_checks++; if (pc !== 5'd5) begin errors++; $display("FAIL mvi_pc: got %0d want 5", pc); end
    endtask

    task automatic test_halt();
        int base; bit ok;
        load_halts(); mem[0] = 9'o010; mem[1] = 9'o010;
        lat = 2; do_reset(); base = log_n;
        pulse_start(); wait_halt(100, ok);
        n_checks++; if (!ok || pc !== 5'd2) begin errors++; $display("FAIL halt_pc: got %0d ok=%b want 2", pc, ok); end
        n_checks++; if (log_n - base !== 2) begin errors++; $display("FAIL halt_runs: got %0d want 2", log_n - base); end
        n_checks++; if ({busy, halted, err} !== 3'b010) begin errors++; $display("FAIL halt_flags: got %b want 010", {busy, halted, err}); end
    endtask

    task automatic test_timeout();
        int base; bit ok;
        load_halts(); mem[0] = 9'o030;
        lat = 0; do_reset(); base = log_n;
        pulse_start(); wait_run(20, ok);
        n_checks++; if (!ok) begin errors++; $display("FAIL tmo_run_wait: got timeout want proc_run"); end
        for (int k = 1; k <= TMO + 1; k++) begin
            @(negedge clk); #1;
            if (k == TMO) begin
                n_checks++; if (err !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL tmo_early: got err=%b halted=%b want 0/0", err, halted); end
            end
        end
        n_checks++; if (err !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL tmo_err: got err=%b halted=%b want 1/1", err, halted); end
        n_checks++; if (pc !== 5'd0) begin errors++; $display("FAIL tmo_pc: got %0d want 0", pc); end
        mem[1] = 9'o700; lat = 1;
        pulse_start();
        n_checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_clear: got err=%b want 0", err); end
        wait_halt(100, ok);
        n_checks++; if (!ok || pc !== 5'd1 || log_n - base !== 2) begin errors++; $display("FAIL tmo_resume: got pc=%0d runs=%0d want 1/2", pc, log_n - base); end
    endtask

    task automatic test_wrap();
        int base; bit ok;
        load_halts();
        for (int a = 0; a < 31; a++) mem[a] = 9'o010;
        lat = 1; do_reset();
        pulse_start(); wait_halt(600, ok);
        n_checks++; if (!ok || pc !== 5'd31) begin errors++; $display("FAIL wrap_reach: got pc=%0d want 31", pc); end
        mem[31] = 9'o120; mem[0] = 9'd55; mem[1] = 9'o700;
        base = log_n;
        pulse_start(); wait_halt(100, ok);
        n_checks++; if (log_n - base !== 1 || log_inst[base] !== 9'o120) begin errors++; $display("FAIL wrap_issue: got runs=%0d inst=%0o want 1/120", log_n - base, log_inst[base]); end
        n_checks++; if (log_next[base] !== 9'd55) begin errors++; $display("FAIL wrap_imm: got %0d want 55", log_next[base]); end
        n_checks++; if (pc !== 5'd1) begin errors++; $display("FAIL wrap_pc: got %0d want 1", pc); end
    endtask

    task automatic test_stop();
        int base; bit ok;
        load_halts(); mem[0] = 9'o010; mem[1] = 9'o010; mem[2] = 9'o010;
        lat = 3; do_reset();
        stop = 1'b1; @(negedge clk); #1; stop = 1'b0;
        pulse_start(); wait_halt(100, ok);
        n_checks++; if (!ok || pc !== 5'd3) begin errors++; $display("FAIL stop_idle_ignored: got pc=%0d want 3", pc); end
        do_reset(); base = log_n;
        pulse_start(); wait_run(20, ok);
        @(negedge clk); #1;
        stop = 1'b1; @(negedge clk); #1; stop = 1'b0;
        wait_halt(50, ok);
        n_checks++; if (!ok || pc !== 5'd1 || log_n - base !== 1) begin errors++; $display("FAIL stop_exec: got pc=%0d runs=%0d want 1/1", pc, log_n - base); end
        start = 1'b1; stop = 1'b1;
        @(negedge clk); #1;
        start = 1'b0; stop = 1'b0;
        wait_halt(100, ok);
        n_checks++; if (!ok || pc !== 5'd3) begin errors++; $display("FAIL start_beats_stop: got pc=%0d want 3", pc); end
    endtask

    task automatic test_reset_exec();
        int rd0; bit ok;
        load_halts(); mem[0] = 9'o010; mem[1] = 9'o030;
        lat = 1; do_reset();
        pulse_start(); wait_run(20, ok);
        @(negedge clk); #1; lat = 0;
        wait_run(20, ok);
        repeat (2) begin @(negedge clk); #1; end
        n_checks++; if (pc !== 5'd1 || busy !== 1'b1) begin errors++; $display("FAIL rst_pre: got pc=%0d busy=%b want 1/1", pc, busy); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (pc !== '0 || {busy, halted, err} !== 3'b000) begin errors++; $display("FAIL rst_exec_state: got pc=%0d flags=%b want 0/000", pc, {busy, halted, err}); end
        n_checks++; if ({bus.mem_rd, bus.proc_run} !== 2'b00 || bus.proc_din !== 9'd0) begin errors++; $display("FAIL rst_exec_bus: got rd/run=%b din=%0o want 00/0", {bus.mem_rd, bus.proc_run}, bus.proc_din); end
        @(negedge clk); #1 reset = 1'b1;
        rd0 = rd_cnt;
        repeat (5) begin @(negedge clk); #1; end
        n_checks++; if (rd_cnt !== rd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_exec_idle: got reads=%0d busy=%b want 0/0", rd_cnt - rd0, busy); end
    endtask

    task automatic test_random();
        logic [8:0] exp_inst [32];
        logic [8:0] exp_imm  [32];
        bit         exp_mvi  [32];
        int n, pos, n_exp, base, p;
        logic [2:0] op;
        bit ok;
        for (int it = 0; it < 8; it++) begin
            load_halts();
            pos = 0;
            n = $urandom_range(3, 12);
            for (int j = 0; j < n; j++) begin
                op = 3'($urandom_range(0, 6));
                mem[pos] = {op, 6'($urandom)};
                pos++;
                if (op == 3'b001) begin mem[pos] = 9'($urandom); pos++; end
            end
            lat = $urandom_range(1, 6);
            // walk the program as the processor should see it
            n_exp = 0; p = 0;
            while (mem[p][8:6] != 3'b111 && n_exp < 32) begin
                exp_inst[n_exp] = mem[p];
                exp_mvi[n_exp]  = (mem[p][8:6] == 3'b001);
                exp_imm[n_exp]  = mem[(p + 1) % 32];
                p = (p + (exp_mvi[n_exp] ? 2 : 1)) % 32;
                n_exp++;
            end
            do_reset(); base = log_n;
            pulse_start(); wait_halt(400, ok);
            n_checks++; if (!ok || log_n - base !== n_exp) begin errors++; $display("FAIL rand%0d_runs: got %0d want %0d", it, log_n - base, n_exp); end
            n_checks++; if (pc !== PC_W'(p) || err !== 1'b0) begin errors++; $display("FAIL rand%0d_pc: got pc=%0d err=%b want %0d/0", it, pc, err, p); end
            for (int k = 0; k < n_exp && k < log_n - base; k++) begin
                n_checks++; if (log_inst[base+k] !== exp_inst[k]) begin errors++; $display("FAIL rand%0d_inst%0d: got %0o want %0o", it, k, log_inst[base+k], exp_inst[k]); end
                n_checks++; if (log_lat[base+k] !== (exp_mvi[k] ? 4 : 2)) begin errors++; $display("FAIL rand%0d_lat%0d: got %0d want %0d", it, k, log_lat[base+k], exp_mvi[k] ? 4 : 2); end
                if (exp_mvi[k]) begin
                    n_checks++; if (log_next[base+k] !== exp_imm[k]) begin errors++; $display("FAIL rand%0d_imm%0d: got %0o want %0o", it, k, log_next[base+k], exp_imm[k]); end
                end
            end
        end
    endtask

    initial begin
        load_halts();
        test_reset();
        test_mv();
        test_mvi();
        test_halt();
        test_timeout();
        test_wrap();
        test_stop();
        test_reset_exec();
        test_random();
        n_checks++; if (inv_viol !== 0) begin errors++; $display("FAIL run_invariants: got %0d violations want 0", inv_viol); end
        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 5, program-counter and memory-address width.
REQ-002 SHALL have parameter TMO, default 7, maximum cycles to wait for proc_done after issue.
REQ-003 SHALL have port clk, input, 1: clock, all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: begin or resume execution from the current pc.
REQ-006 SHALL have port stop, input, 1: halt after the current instruction completes.
REQ-007 SHALL have port mem_rd, output, 1: read strobe to the synchronous program memory.
REQ-008 SHALL have port mem_addr, output, PC_W: memory read address.
REQ-009 SHALL have port mem_data, input, 9: memory read data, valid the cycle after mem_rd.
REQ-010 SHALL have port proc_din, output, 9: instruction or immediate word to the processor data input.
REQ-011 SHALL have port proc_run, output, 1: one-cycle instruction-issue pulse to the processor.
REQ-012 SHALL have port proc_done, input, 1: processor completion flag.
REQ-013 SHALL have port pc, output, PC_W: address of the next instruction to fetch.
REQ-014 SHALL have ports busy, halted, err, output, 1 each: executing; stopped by halt opcode or stop; done timeout.

Function
REQ-015 SHALL implement the states IDLE, F1, L1, F2, L2, ISSUE, IMM, EXEC, HALT.
REQ-016 IDLE: on start, SHALL go to F1; otherwise SHALL stay in IDLE.
REQ-017 F1: SHALL assert mem_rd with mem_addr=pc for one cycle, then go to L1.
REQ-018 L1: SHALL capture mem_data into the instruction register (bits [8:6] = opcode).
REQ-018a L1, opcode 3'b111 (halt): SHALL go to HALT with pc unchanged.
REQ-018b L1, opcode 3'b001 (mvi): SHALL go to F2.
REQ-018c L1, any other opcode: SHALL go to ISSUE.
REQ-019 F2/L2: SHALL read mem_addr=pc+1 (mod 2^PC_W), capture the immediate register, then go to ISSUE.
REQ-020 ISSUE: SHALL drive proc_din=instruction and proc_run=1 for exactly one cycle.
REQ-021 After ISSUE: for mvi, SHALL go to IMM and drive proc_din=immediate for one cycle, then go to EXEC; for any other opcode, SHALL go straight to EXEC.
REQ-022 EXEC: SHALL hold proc_din at the immediate word (mvi) or the instruction (other opcodes).
REQ-022a EXEC: SHALL count cycles since leaving ISSUE.
REQ-022b EXEC: proc_done=1 SHALL be accepted in IMM or EXEC.
REQ-023 On done: SHALL advance pc by 2 (mvi) or 1 (other opcodes), modulo 2^PC_W (wraps to 0).
REQ-023a On done: SHALL go to HALT if stop was latched, otherwise to F1.
REQ-024 If the count reaches TMO without proc_done: SHALL set err=1, leave pc unchanged, and go to HALT.
REQ-025 stop pulses in any busy state SHALL be latched and take effect only at instruction completion.
REQ-025a stop in IDLE SHALL be ignored.
REQ-026 HALT: start SHALL clear err, clear the stop latch and go to F1.
REQ-026a stop and start asserted in the same cycle in HALT: start SHALL win.
REQ-027 proc_run SHALL never be asserted outside ISSUE.
REQ-027a proc_run SHALL be 0 whenever mem_rd is 1.
REQ-028 busy SHALL be 1 in F1..EXEC; halted SHALL be 1 only in HALT.
REQ-029 Minimum instruction latency from F1 to proc_run: 2 cycles (non-mvi), 4 cycles (mvi).

Reset
REQ-030 reset=0 at any time, including mid-EXEC, SHALL immediately force IDLE, pc=0, proc_run=0, mem_rd=0, proc_din=0, busy=0, halted=0, err=0, and clear the stop latch.
REQ-031 After reset release: no memory read and no proc_run SHALL occur until start=1.

Verification
REQ-032 Bench: mem[0]=9'o010 (mv R1,R0), proc_done 1 cycle after run, start -> single proc_run with proc_din=9'o010, pc becomes 1.
REQ-033 Bench: mem[3]=9'o120 (mvi R2), mem[4]=9'd77 -> proc_din=9'o120 in the run cycle, 9'd77 the next cycle, pc 3->5.
REQ-034 Bench: mem[2]=9'o700 -> HALT with pc=2, halted=1, no proc_run issued.
REQ-035 Bench: proc_done held 0 -> err=1 exactly TMO=7 cycles after leaving ISSUE; pc unchanged; start clears err.
REQ-036 Bench: pc=31 (PC_W=5) with mvi -> immediate read from address 0, pc wraps to 1.
REQ-037 Bench: stop pulse in EXEC then done -> pc advances and state enters HALT; reset mid-EXEC -> all outputs 0 and pc=0.
